// File: rtl/led_rotator_pkg.sv
// Shared types for the LED rotator: display mode encoding and the mode used
// when nothing else is selected.
package led_rotator_pkg;

  typedef enum logic [1:0] {
    ROTATE = 2'b00,
    CLAMP  = 2'b01,
    BAR    = 2'b10,
    HOLD   = 2'b11
  } mode_t;

  localparam mode_t MODE_DEFAULT = ROTATE;

endpackage

// File: rtl/rot_edge_detect.sv
// Encoder event front end: optional 2-flop synchroniser (LED_ROTATOR_SYNC_EN)
// followed by a rising-edge detector producing a one-cycle step and its direction.
module rot_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic event_in,
  input  logic dir_in,
  output logic step,
  output logic dir
);

  logic ev_cur;
  logic ev_prev;

`ifdef LED_ROTATOR_SYNC_EN
  logic [1:0] ev_sync;
  logic [1:0] dir_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_sync  <= 2'b11;
      dir_sync <= 2'b11;
    end else begin
      ev_sync  <= {ev_sync[0], event_in};
      dir_sync <= {dir_sync[0], dir_in};
    end
  end

  assign ev_cur = ev_sync[1];
  assign dir    = dir_sync[1];
`else
  assign ev_cur = event_in;
  assign dir    = dir_in;
`endif

  // Previous value resets high so an event held through reset is not a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_prev <= 1'b1;
    end else begin
      ev_prev <= ev_cur;
    end
  end

  assign step = ev_cur & ~ev_prev;

endmodule

// File: rtl/led_rotator_n.sv
// Rotary-encoder driven LED position indicator with rotate/clamp/bar/hold modes.
// Define LED_ROTATOR_SYNC_EN to synchronise the encoder inputs (2 extra cycles).
module led_rotator_n
  import led_rotator_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int INIT_POS = 3,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rotation_event,
  input  logic                     rotation_direction,
  input  logic [1:0]               mode,
  input  logic                     load,
  input  logic [$clog2(WIDTH)-1:0] load_pos,
  output logic [WIDTH-1:0]         led,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     at_limit,
  output logic [CNT_W-1:0]         event_cnt
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] POS_MAX  = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_INIT = PW'(INIT_POS);

  mode_t            mode_cur;
  logic             step;
  logic             dir;
  logic [PW-1:0]    pos_q;
  logic [PW-1:0]    pos_d;
  logic [PW-1:0]    pos_up;
  logic [PW-1:0]    pos_dn;
  logic [PW-1:0]    load_clamped;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign mode_cur = mode_t'(mode);

  rot_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .event_in (rotation_event),
    .dir_in   (rotation_direction),
    .step     (step),
    .dir      (dir)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= POS_INIT;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      cnt_q <= cnt_d;
    end
  end

  assign pos_up       = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
  assign pos_dn       = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
  assign load_clamped = ({1'b0, load_pos} > {1'b0, POS_MAX}) ? POS_MAX : load_pos;

  // Load wins over a coincident step; the step is simply lost.
  always_comb begin
    pos_d = pos_q;
    cnt_d = cnt_q;
    if (load) begin
      pos_d = load_clamped;
    end else if (step) begin
      case (mode_cur)
        ROTATE: begin
          pos_d = dir ? pos_up : pos_dn;
          cnt_d = cnt_q + CNT_W'(1);
        end
        CLAMP, BAR: begin
          if (dir ? (pos_q != POS_MAX) : (pos_q != '0)) begin
            pos_d = dir ? pos_up : pos_dn;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    led = '0;
    if (mode_cur == BAR) begin
      for (int i = 0; i < WIDTH; i++) begin
        led[i] = (PW'(i) <= pos_q);
      end
    end else begin
      led[pos_q] = 1'b1;
    end
  end

  assign at_limit  = (pos_q == '0) || (pos_q == POS_MAX);
  assign pos       = pos_q;
  assign event_cnt = cnt_q;

endmodule

// File: doc/led_rotator_n.md
LED_ROTATOR_N -- requirements
Module: led_rotator_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of LEDs, legal range 2..64.
REQ-002 SHALL have parameter INIT_POS, default 3: reset position index, range 0..WIDTH-1.
REQ-003 SHALL have parameter CNT_W, default 8: width of the event counter.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 rotation_event  input  1  encoder event strobe; a step occurs on each 0->1 transition.
REQ-008 rotation_direction  input  1  step direction; 0 = toward led[0], 1 = toward led[WIDTH-1].
REQ-009 mode  input  2  display mode: 00 ROTATE, 01 CLAMP, 10 BAR, 11 HOLD.
REQ-010 load  input  1  synchronous position load strobe.
REQ-011 load_pos  input  $clog2(WIDTH)  position value to load.
REQ-012 led  output  WIDTH  LED pattern.
REQ-013 pos  output  $clog2(WIDTH)  current position index.
REQ-014 at_limit  output  1  pos==0 or pos==WIDTH-1.
REQ-015 event_cnt  output  CNT_W  count of accepted steps, wrapping.

Function
REQ-016 SHALL detect a step when the registered previous event value is 0 and the current (optionally synchronised) event value is 1.
REQ-017 SHALL update pos, led and event_cnt on the clock edge at which the step is detected; no further latency.
REQ-018 ROTATE: direction 1 sets pos to pos+1, wrapping WIDTH-1 to 0; direction 0 sets pos to pos-1, wrapping 0 to WIDTH-1.
REQ-019 CLAMP: same as ROTATE, except pos saturates at 0 and WIDTH-1; a step into a limit is dropped and event_cnt does not increment.
REQ-020 BAR: pos steps as in CLAMP; led[i]=1 for every i<=pos.
REQ-021 ROTATE, CLAMP and HOLD SHALL show one-hot led[pos].
REQ-022 HOLD: steps are ignored and pos, led and event_cnt keep their values; edge tracking continues.
REQ-023 load=1 SHALL set pos to load_pos on the next edge; load takes priority over a simultaneous step, which is dropped.
REQ-024 A load_pos >= WIDTH SHALL be clamped to WIDTH-1.
REQ-025 event_cnt SHALL increment by 1 per accepted step and wrap from all-ones to 0.
REQ-026 A mode change SHALL take effect on the next step, with no change to pos.
REQ-027 led and at_limit SHALL be combinational decodes of the registered pos and mode.

Reset
REQ-028 When rst_n=0: pos=INIT_POS, event_cnt=0, the previous-event register is 1, and synchroniser flops are 1.
REQ-029 After reset, led shall be one-hot at INIT_POS (BAR: bits 0..INIT_POS set).
REQ-030 A reset asserted mid-operation SHALL abort any pending step; no step is detected on the first cycle after release while the event is high.

Configuration
REQ-031 SHALL use macro LED_ROTATOR_SYNC_EN.
REQ-032 When LED_ROTATOR_SYNC_EN is defined: rotation_event and rotation_direction each pass through a 2-flop synchroniser, adding 2 cycles of step latency.
REQ-033 When LED_ROTATOR_SYNC_EN is undefined: the inputs are sampled directly and the step latency is as in REQ-017.

Structure
REQ-034 Package led_rotator_pkg SHALL hold the mode enum (ROTATE, CLAMP, BAR, HOLD) and the constant 2'b00 default mode.
REQ-035 Sub-module rot_edge_detect SHALL contain the optional synchroniser and the rising-edge detector, and SHALL output step and dir.

Verification
REQ-036 Reset, WIDTH=8, INIT_POS=3, ROTATE, 5 steps with direction 0 -> pos 3,2,1,0,7,6, led=8'h40, event_cnt=5.
REQ-037 CLAMP at pos 6, 3 steps with direction 1 -> pos 7, 7, 7, at_limit=1, event_cnt +1 only.
REQ-038 BAR, load_pos=4, then 1 step with direction 0 -> led=8'h1F then 8'h0F.
REQ-039 load=1 in the same cycle as a step, load_pos=2 -> pos=2, event_cnt unchanged; HOLD with 4 steps -> no change.
REQ-040 event held high for 10 cycles -> exactly 1 step; rst_n pulsed low mid-run -> pos=3, event_cnt=0; with SYNC_EN the step appears 2 cycles later.
